// File: rtl/audio_mixer_n.sv
// Multi-channel audio mixer: per-channel gain/mute/signedness, one shared MAC,
// saturation to OUT_W signed bits with sticky clip and overrun flags.
//
// state | meaning
// IDLE  | waiting for sample_en; inputs and gains are snapshotted on the strobe
// ACC   | one channel per cycle accumulated into acc (CHANNELS cycles)
// SAT   | scale by 1/8, saturate, publish audio_o with a one-cycle valid_o
module audio_mixer_n #(
  parameter int CHANNELS = 4,
  parameter int IN_W     = 16,
  parameter int OUT_W    = 16,
  parameter int GAIN_W   = 4,
  localparam int SEL_W   = $clog2(CHANNELS),
  localparam int ACC_W   = IN_W + GAIN_W + $clog2(CHANNELS) + 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     sample_en,
  input  logic [CHANNELS*IN_W-1:0] ch_data,
  input  logic [CHANNELS-1:0]      ch_signed,
  input  logic [CHANNELS-1:0]      mute,
  input  logic                     gain_wr,
  input  logic [SEL_W-1:0]         gain_sel,
  input  logic [GAIN_W-1:0]        gain_din,
  input  logic                     clip_clr,
  output logic [OUT_W-1:0]         audio_o,
  output logic                     valid_o,
  output logic                     busy_o,
  output logic                     clip_o,
  output logic                     overrun_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    SAT  = 2'd2
  } state_t;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

  state_t                   state;
  logic [GAIN_W-1:0]        gain    [CHANNELS];
  logic [GAIN_W-1:0]        gain_sh [CHANNELS];
  logic [IN_W-1:0]          data_sh [CHANNELS];
  logic [CHANNELS-1:0]      signed_sh;
  logic [CHANNELS-1:0]      mute_sh;
  logic [SEL_W-1:0]         idx;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  ext_w;
  logic signed [ACC_W-1:0]  gain_w;
  logic signed [ACC_W-1:0]  term;
  logic signed [ACC_W-1:0]  sat_s;
  logic [IN_W-1:0]          cur;
  logic                     fill;
  logic                     clip_set;
  logic                     ovr_set;

  // Live gain registers; the mix itself only ever reads the snapshot in gain_sh.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) gain[i] <= GAIN_W'(8);
    end else if (gain_wr && ({1'b0, gain_sel} < (SEL_W + 1)'(CHANNELS))) begin
      gain[gain_sel] <= gain_din;
    end
  end

  always_comb begin
    cur      = data_sh[idx];
    fill     = signed_sh[idx] & cur[IN_W-1];
    ext_w    = {{(ACC_W - IN_W){fill}}, cur};
    gain_w   = {{(ACC_W - GAIN_W){1'b0}}, gain_sh[idx]};
    term     = mute_sh[idx] ? '0 : ext_w * gain_w;
    sat_s    = acc >>> 3;
    ovr_set  = sample_en && (state != IDLE);
    clip_set = (state == SAT) && ((sat_s > SAT_MAX) || (sat_s < SAT_MIN));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      idx       <= '0;
      acc       <= '0;
      audio_o   <= '0;
      valid_o   <= 1'b0;
      busy_o    <= 1'b0;
      clip_o    <= 1'b0;
      overrun_o <= 1'b0;
      signed_sh <= '0;
      mute_sh   <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        data_sh[i] <= '0;
        gain_sh[i] <= '0;
      end
    end else begin
      valid_o   <= 1'b0;
      // A new event in the same cycle as clip_clr keeps the flag set.
      clip_o    <= clip_set | (clip_o & ~clip_clr);
      overrun_o <= ovr_set | (overrun_o & ~clip_clr);
      case (state)
        IDLE: begin
          if (sample_en) begin
            for (int i = 0; i < CHANNELS; i++) begin
              data_sh[i] <= ch_data[i*IN_W +: IN_W];
              gain_sh[i] <= gain[i];
            end
            signed_sh <= ch_signed;
            mute_sh   <= mute;
            acc       <= '0;
            idx       <= '0;
            busy_o    <= 1'b1;
            state     <= ACC;
          end
        end
        ACC: begin
          acc <= acc + term;
          idx <= idx + SEL_W'(1);
          if (idx == SEL_W'(CHANNELS - 1)) state <= SAT;
        end
        SAT: begin
          if (sat_s > SAT_MAX)      audio_o <= SAT_MAX[OUT_W-1:0];
          else if (sat_s < SAT_MIN) audio_o <= SAT_MIN[OUT_W-1:0];
          else                      audio_o <= sat_s[OUT_W-1:0];
          valid_o <= 1'b1;
          busy_o  <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_mixer_n.sv
// Self-checking bench for audio_mixer_n: directed scenarios plus randomized mixes
// compared against an integer-arithmetic model of the mix rules.
module tb_audio_mixer_n;
  localparam int CH     = 4;
  localparam int IN_W   = 16;
  localparam int OUT_W  = 16;
  localparam int GAIN_W = 4;
  localparam int SEL_W  = 2;
  localparam int LAT    = CH + 1;
  localparam longint MAXV = (64'sd1 <<< (OUT_W - 1)) - 1;
  localparam longint MINV = -MAXV - 1;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 sample_en = 1'b0;
  logic [CH*IN_W-1:0]   ch_data = '0;
  logic [CH-1:0]        ch_signed = '0;
  logic [CH-1:0]        mute = '0;
  logic                 gain_wr = 1'b0;
  logic [SEL_W-1:0]     gain_sel = '0;
  logic [GAIN_W-1:0]    gain_din = '0;
  logic                 clip_clr = 1'b0;
  logic [OUT_W-1:0]     audio_o;
  logic                 valid_o;
  logic                 busy_o;
  logic                 clip_o;
  logic                 overrun_o;

  int  m_gain [CH];
  bit  m_clip;
  int  n_cmp = 0;
  int  n_fail = 0;

  audio_mixer_n #(.CHANNELS(CH), .IN_W(IN_W), .OUT_W(OUT_W), .GAIN_W(GAIN_W)) dut (
    .clk(clk), .reset_n(reset_n), .sample_en(sample_en), .ch_data(ch_data),
    .ch_signed(ch_signed), .mute(mute), .gain_wr(gain_wr), .gain_sel(gain_sel),
    .gain_din(gain_din), .clip_clr(clip_clr), .audio_o(audio_o), .valid_o(valid_o),
    .busy_o(busy_o), .clip_o(clip_o), .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;

  function automatic logic [OUT_W-1:0] model(output bit clipped);
    longint sum, v, s;
    logic [IN_W-1:0] d;
    sum = 0;
    for (int i = 0; i < CH; i++) begin
      d = ch_data[i*IN_W +: IN_W];
      v = ch_signed[i] ? longint'($signed(d)) : longint'(d);
      if (!mute[i]) sum += v * longint'(m_gain[i]);
    end
    s = sum >>> 3;
    clipped = 1'b0;
    if (s > MAXV) begin s = MAXV; clipped = 1'b1; end
    else if (s < MINV) begin s = MINV; clipped = 1'b1; end
    return s[OUT_W-1:0];
  endfunction

  task automatic set_ch(input int ch, input logic [IN_W-1:0] v);
    ch_data[ch*IN_W +: IN_W] = v;
  endtask

  task automatic set_gain(input int ch, input int g);
    logic [31:0] c, gv;
    c = ch; gv = g;
    @(negedge clk);
    gain_wr = 1'b1; gain_sel = c[SEL_W-1:0]; gain_din = gv[GAIN_W-1:0];
    @(negedge clk);
    gain_wr = 1'b0;
    m_gain[ch] = g;
  endtask

  task automatic pulse_clr();
    @(negedge clk); clip_clr = 1'b1;
    @(negedge clk); clip_clr = 1'b0;
  endtask

  // Strobe once, wait (bounded) for valid_o; lat counts negedges after the capturing edge.
  task automatic run_mix(output logic [OUT_W-1:0] res, output int lat, output int pulses);
    @(negedge clk); sample_en = 1'b1;
    @(negedge clk); sample_en = 1'b0;
    lat = 0;
    while (valid_o !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    res = audio_o;
    pulses = (valid_o === 1'b1) ? 1 : 0;
    for (int i = 0; i < 3; i++) begin @(negedge clk); pulses += (valid_o === 1'b1) ? 1 : 0; end
  endtask

  task automatic test_reset();
    logic [OUT_W-1:0] r, e; int lat, p; bit c;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (audio_o !== 16'h0000) begin n_fail++; $display("FAIL reset_audio got %h want 0000", audio_o); end
    n_cmp++; if ({valid_o, busy_o, clip_o, overrun_o} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got %b want 0000", {valid_o, busy_o, clip_o, overrun_o}); end
    for (int i = 0; i < CH; i++) set_ch(i, IN_W'($urandom_range(0, 16'h1FFF)));
    ch_signed = CH'($urandom); mute = '0;
    e = model(c);
    run_mix(r, lat, p);
    n_cmp++; if (r !== e) begin n_fail++; $display("FAIL reset_unity_gain got %h want %h", r, e); end
  endtask

  task automatic test_basic();
    logic [OUT_W-1:0] r; int lat, p;
    ch_data = '0; set_ch(0, 16'h1000); set_ch(1, 16'h2000);
    ch_signed = '1; mute = '0;
    run_mix(r, lat, p);
    n_cmp++; if (r !== 16'h3000) begin n_fail++; $display("FAIL basic_sum got %h want 3000", r); end
    n_cmp++; if (lat !== LAT) begin n_fail++; $display("FAIL basic_latency got %0d want %0d", lat, LAT); end
    n_cmp++; if (p !== 1) begin n_fail++; $display("FAIL basic_valid_pulses got %0d want 1", p); end
    n_cmp++; if (clip_o !== 1'b0) begin n_fail++; $display("FAIL basic_clip got %b want 0", clip_o); end
  endtask

  task automatic test_clip();
    logic [OUT_W-1:0] r; int lat, p;
    for (int i = 0; i < CH; i++) set_gain(i, 15);
    for (int i = 0; i < CH; i++) set_ch(i, 16'h7FFF);
    ch_signed = '1; mute = '0;
    run_mix(r, lat, p);
    n_cmp++; if (r !== 16'h7FFF) begin n_fail++; $display("FAIL clip_pos got %h want 7fff", r); end
    n_cmp++; if (clip_o !== 1'b1) begin n_fail++; $display("FAIL clip_pos_flag got %b want 1", clip_o); end
    pulse_clr();
    n_cmp++; if (clip_o !== 1'b0) begin n_fail++; $display("FAIL clip_clr got %b want 0", clip_o); end
    for (int i = 0; i < CH; i++) set_ch(i, 16'h8000);
    run_mix(r, lat, p);
    n_cmp++; if (r !== 16'h8000) begin n_fail++; $display("FAIL clip_neg got %h want 8000", r); end
    n_cmp++; if (clip_o !== 1'b1) begin n_fail++; $display("FAIL clip_neg_flag got %b want 1", clip_o); end
    pulse_clr();
    m_clip = 1'b0;
  endtask

  task automatic test_unsigned();
    logic [OUT_W-1:0] r; int lat, p;
    set_gain(0, 4);
    ch_data = '0; set_ch(0, 16'hFFFF);
    ch_signed = 4'b1110; mute = 4'b1110;
    run_mix(r, lat, p);
    n_cmp++; if (r !== 16'h7FFF) begin n_fail++; $display("FAIL unsigned_max got %h want 7fff", r); end
    n_cmp++; if (clip_o !== 1'b0) begin n_fail++; $display("FAIL unsigned_clip got %b want 0", clip_o); end
    ch_signed = 4'b1111;
    run_mix(r, lat, p);
    n_cmp++; if (r !== 16'hFFFF) begin n_fail++; $display("FAIL signed_minus1 got %h want ffff", r); end
    mute = '0;
  endtask

  task automatic test_gain_during_acc();
    logic [OUT_W-1:0] r; int lat, p;
    for (int i = 0; i < CH; i++) set_gain(i, 8);
    ch_data = '0; set_ch(1, 16'h0100); ch_signed = '1; mute = '0;
    @(negedge clk); sample_en = 1'b1;
    @(negedge clk); sample_en = 1'b0;
    gain_wr = 1'b1; gain_sel = 2'd1; gain_din = '0;
    @(negedge clk); gain_wr = 1'b0; m_gain[1] = 0;
    lat = 0;
    while (valid_o !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    n_cmp++; if (valid_o !== 1'b1 || audio_o !== 16'h0100) begin n_fail++; $display("FAIL gain_snapshot got %h valid %b want 0100", audio_o, valid_o); end
    run_mix(r, lat, p);
    n_cmp++; if (r !== 16'h0000) begin n_fail++; $display("FAIL gain_next_sample got %h want 0000", r); end
    set_gain(1, 8);
  endtask

  task automatic test_overrun();
    logic [OUT_W-1:0] e; int p; bit c;
    for (int i = 0; i < CH; i++) set_ch(i, IN_W'($urandom_range(0, 16'h0FFF)));
    e = model(c);
    @(negedge clk); sample_en = 1'b1;
    @(negedge clk); sample_en = 1'b0;
    @(negedge clk); sample_en = 1'b1;
    @(negedge clk); sample_en = 1'b0;
    p = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (valid_o === 1'b1) begin
        p++;
        n_cmp++; if (audio_o !== e) begin n_fail++; $display("FAIL overrun_data got %h want %h", audio_o, e); end
      end
    end
    n_cmp++; if (p !== 1) begin n_fail++; $display("FAIL overrun_pulses got %0d want 1", p); end
    n_cmp++; if (overrun_o !== 1'b1) begin n_fail++; $display("FAIL overrun_flag got %b want 1", overrun_o); end
    pulse_clr();
    n_cmp++; if (overrun_o !== 1'b0) begin n_fail++; $display("FAIL overrun_clr got %b want 0", overrun_o); end
    // strobe landing exactly in the SAT cycle
    @(negedge clk); sample_en = 1'b1;
    @(negedge clk); sample_en = 1'b0;
    repeat (LAT - 1) @(negedge clk);
    sample_en = 1'b1;
    p = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk); sample_en = 1'b0;
      p += (valid_o === 1'b1) ? 1 : 0;
    end
    n_cmp++; if (p !== 1 || overrun_o !== 1'b1) begin n_fail++; $display("FAIL overrun_sat got pulses %0d flag %b want 1 1", p, overrun_o); end
    pulse_clr();
  endtask

  task automatic test_back_to_back();
    logic [OUT_W-1:0] e1, e2; int lat; bit c;
    ch_data = '0; set_ch(0, 16'h0123); set_ch(2, 16'h0400);
    e1 = model(c);
    @(negedge clk); sample_en = 1'b1;
    @(negedge clk); sample_en = 1'b0;
    lat = 0;
    while (valid_o !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    n_cmp++; if (audio_o !== e1) begin n_fail++; $display("FAIL b2b_first got %h want %h", audio_o, e1); end
    set_ch(3, 16'h0200);
    e2 = model(c);
    sample_en = 1'b1;
    @(negedge clk); sample_en = 1'b0;
    lat = 0;
    while (valid_o !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    n_cmp++; if (audio_o !== e2 || lat !== LAT) begin n_fail++; $display("FAIL b2b_second got %h lat %0d want %h lat %0d", audio_o, lat, e2, LAT); end
    n_cmp++; if (overrun_o !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun got %b want 0", overrun_o); end
  endtask

  task automatic test_random();
    logic [OUT_W-1:0] r, e; int lat, p; bit c;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 1) set_gain($urandom_range(0, CH - 1), $urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) begin pulse_clr(); m_clip = 1'b0; end
      for (int i = 0; i < CH; i++) set_ch(i, IN_W'($urandom));
      ch_signed = CH'($urandom); mute = CH'($urandom);
      e = model(c);
      if (c) m_clip = 1'b1;
      run_mix(r, lat, p);
      n_cmp++; if (r !== e || p !== 1) begin n_fail++; $display("FAIL random_mix[%0d] got %h pulses %0d want %h", n, r, p, e); end
      n_cmp++; if (clip_o !== m_clip) begin n_fail++; $display("FAIL random_clip[%0d] got %b want %b", n, clip_o, m_clip); end
    end
  endtask

  task automatic test_reset_mid();
    logic [OUT_W-1:0] r, e; int lat, p; bit c;
    set_gain(0, 0); set_gain(2, 3);
    ch_data = '0; set_ch(0, 16'h0800); set_ch(2, 16'h0010); ch_signed = '1; mute = '0;
    run_mix(r, lat, p);
    @(negedge clk); sample_en = 1'b1;
    @(negedge clk); sample_en = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_cmp++; if ({audio_o, valid_o, busy_o, clip_o, overrun_o} !== '0) begin n_fail++; $display("FAIL midreset_outputs got %h %b%b%b%b want all 0", audio_o, valid_o, busy_o, clip_o, overrun_o); end
    for (int i = 0; i < CH; i++) m_gain[i] = 8;
    m_clip = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    p = 0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); p += (valid_o === 1'b1) ? 1 : 0; end
    n_cmp++; if (p !== 0) begin n_fail++; $display("FAIL midreset_valid got %0d pulses want 0", p); end
    e = model(c);
    run_mix(r, lat, p);
    n_cmp++; if (r !== e || r !== 16'h0810) begin n_fail++; $display("FAIL midreset_gains got %h want %h", r, e); end
  endtask

  initial begin
    for (int i = 0; i < CH; i++) m_gain[i] = 8;
    m_clip = 1'b0;
    test_reset();
    test_basic();
    test_clip();
    test_unsigned();
    test_gain_during_acc();
    test_overrun();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/audio_mixer_n.md
Name: audio_mixer_n

Overview:
- Parametrised successor to the fixed PSG+PCM+keybeep+cassette mix-and-compress path in the MSX1 top level.
- Sums CHANNELS audio sources, each with a per-channel gain, mute bit and signed/unsigned mode, using one time-multiplexed multiply-accumulate.
- Saturates the result to OUT_W signed bits, raises a sticky clip flag and presents one output sample per sample_en strobe.
- Sits between the sound sources (jt49 PSG, slot sound, keyclick, cassette) and the platform audio output.

Parameters:
- CHANNELS, 4, number of input channels (2..16).
- IN_W, 16, width of each input channel.
- OUT_W, 16, signed output width (OUT_W <= IN_W+1).
- GAIN_W, 4, per-channel gain width; gain is value/8, so 8 = unity and 15 = 1.875x.
- ACC_W, IN_W+GAIN_W+$clog2(CHANNELS)+1, accumulator width. Derived; the instantiator does not override it.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- sample_en  in  1  one-cycle strobe that starts a mix.
- ch_data  in  CHANNELS*IN_W  flattened inputs; channel i occupies [i*IN_W +: IN_W].
- ch_signed  in  CHANNELS  1 = two's complement input, 0 = unsigned input (zero-extended).
- mute  in  CHANNELS  1 = channel contributes 0.
- gain_wr  in  1  gain register write strobe.
- gain_sel  in  $clog2(CHANNELS)  gain register index.
- gain_din  in  GAIN_W  gain value to write.
- clip_clr  in  1  clears clip_o and overrun_o.
- audio_o  out  OUT_W  mixed signed sample, held between updates.
- valid_o  out  1  one-cycle pulse when audio_o updates.
- busy_o  out  1  high while a mix is in progress.
- clip_o  out  1  sticky saturation flag.
- overrun_o  out  1  sticky flag: sample_en arrived while busy.

Behaviour:
- Reset (async assert, sync release):
  - audio_o=0, valid_o=0, busy_o=0, clip_o=0, overrun_o=0.
  - All gain registers = 8 (unity). FSM = IDLE.
  - Reset mid-mix abandons the mix; no valid_o is produced.
- Gain registers:
  - On gain_wr, gain[gain_sel] <= gain_din on the next edge.
  - A gain_sel >= CHANNELS write is ignored.
  - Writes are accepted in any state.
- FSM IDLE -> ACC -> SAT -> IDLE.
- IDLE:
  - On sample_en, snapshot ch_data, ch_signed, mute and all gains into shadow registers.
  - acc <= 0, idx <= 0, busy_o <= 1, then go to ACC.
- ACC (CHANNELS cycles):
  - Each cycle, acc <= acc + ext(ch[idx]) * gain[idx], where ext sign-extends signed channels and zero-extends unsigned ones to IN_W+1 bits.
  - A muted channel adds 0.
  - idx increments; after idx = CHANNELS-1, go to SAT.
  - A gain write during ACC does not affect the current mix; the snapshot is used. The new gain applies from the next sample_en.
- SAT (1 cycle):
  - s = acc >>> 3 (arithmetic shift).
  - If s > 2^(OUT_W-1)-1, audio_o = 2^(OUT_W-1)-1 and clip_o <= 1.
  - If s < -2^(OUT_W-1), audio_o = -2^(OUT_W-1) and clip_o <= 1.
  - Otherwise audio_o = s[OUT_W-1:0].
  - valid_o <= 1 for one cycle, busy_o <= 0, return to IDLE.
- Latency: sample_en sampled at edge 0 gives valid_o high in the cycle after edge CHANNELS+1.
  - With CHANNELS=4, valid_o is high 6 cycles after the strobe cycle.
  - Throughput is one mix per CHANNELS+2 cycles.
- sample_en while busy_o=1 (including the SAT cycle) is ignored and sets overrun_o.
- clip_clr clears clip_o and overrun_o. If clip_clr coincides with a new clip or overrun event, the set wins.
- audio_o changes only in SAT; it holds its value otherwise.

Test Plan:
- Reset -> audio_o=0000, valid_o=0, clip_o=0, overrun_o=0; read back via a mix that all gains are 8 (unity).
- CHANNELS=4, all signed, ch0=0x1000, ch1=0x2000, ch2=ch3=0, sample_en -> audio_o=0x3000, valid_o exactly 6 cycles later for 1 cycle, clip_o=0.
- Four channels=0x7FFF, gains=15 -> audio_o=0x7FFF, clip_o=1; then clip_clr -> clip_o=0. Repeat with 0x8000 -> audio_o=0x8000, clip_o=1.
- ch0=0xFFFF unsigned, gain=4, others muted -> audio_o=0x7FFF with clip_o=0 (65535*4/8=32767); same input as signed -> 0xFFFF.
- Gain write ch1=0 during ACC with ch1=0x0100 -> current sample includes 0x0100; next sample excludes it.
- sample_en pulsed again 2 cycles after the first -> overrun_o=1, only one valid_o pulse; reset_n asserted mid-ACC -> no valid_o, all outputs at reset values.
